// File: rtl/vco_adc_pkg.sv
// Shared types and constants for the vco_adc2 sequencer/decimator.
package vco_adc_pkg;
  localparam int CNT_W_DEFAULT   = 16;
  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACQUIRE
  } state_t;
endpackage

// File: rtl/vco_adc_sync.sv
// Generic multi-flop single-bit synchronizer with asynchronous clear,
// used for any vco_adc2 output that is asynchronous to clk.
module vco_adc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[STAGES-2:0], d};
  end

  assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/vco_adc_ctrl.sv
// Enables the vco_adc2 macro, waits out a settle time, then counts ones in
// the quantizer stream per window and hands each count to a 1-entry buffer.
module vco_adc_ctrl
  import vco_adc_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_continuous,
  input  logic [CNT_W-1:0] cfg_settle,
  input  logic [CNT_W-1:0] cfg_window,
  output logic             adc_enable,
  input  logic             adc_q,
  output logic [CNT_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy
);
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt, win_cnt, acc;
  logic [CNT_W-1:0] settle_reg, window_reg;
  logic             cont_reg;
  logic             qs;

  logic [CNT_W-1:0] settle_eff, window_eff, sample_new;
  logic             start_accept, sample_done;

  vco_adc_sync #(.STAGES(SYNC_N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (adc_q),
    .q   (qs)
  );

  // Settle must cover the synchronizer lag; a zero window still yields one bit.
  assign settle_eff   = (cfg_settle < CNT_W'(SYNC_N)) ? CNT_W'(SYNC_N) : cfg_settle;
  assign window_eff   = (cfg_window == '0) ? ONE : cfg_window;
  assign start_accept = (state == IDLE) && cfg_start && !cfg_stop;
  assign sample_done  = (state == ACQUIRE) && (win_cnt == window_reg - ONE) && !cfg_stop;
  assign sample_new   = acc + CNT_W'(qs);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      adc_enable <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      settle_reg <= '0;
      window_reg <= '0;
      cont_reg   <= 1'b0;
    end else if (cfg_stop) begin
      state      <= IDLE;
      adc_enable <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            settle_reg <= settle_eff;
            window_reg <= window_eff;
            cont_reg   <= cfg_continuous;
            settle_cnt <= '0;
            adc_enable <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == settle_reg - ONE) begin
            win_cnt <= '0;
            acc     <= '0;
            state   <= ACQUIRE;
          end else begin
            settle_cnt <= settle_cnt + ONE;
          end
        end
        ACQUIRE: begin
          if (sample_done) begin
            win_cnt <= '0;
            acc     <= '0;
            if (!cont_reg) begin
              state      <= IDLE;
              adc_enable <= 1'b0;
            end
          end else begin
            win_cnt <= win_cnt + ONE;
            acc     <= sample_new;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A finished window replaces the held sample only if it is free or being taken now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (start_accept) overrun <= 1'b0;
      if (sample_done) begin
        if (!sample_valid || sample_ready) begin
          sample_data  <= sample_new;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vco_adc_ctrl.sv
// Self-checking bench for vco_adc_ctrl: table-driven conversions with a
// sample scoreboard, plus hand-written backpressure/stop/reset sequences.
module tb_vco_adc_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_start = 1'b0;
  logic             cfg_stop = 1'b0;
  logic             cfg_continuous = 1'b0;
  logic [CNT_W-1:0] cfg_settle = '0;
  logic [CNT_W-1:0] cfg_window = '0;
  logic             adc_enable;
  logic             adc_q = 1'b0;
  logic [CNT_W-1:0] sample_data;
  logic             sample_valid;
  logic             sample_ready = 1'b1;
  logic             overrun;
  logic             busy;

  vco_adc_ctrl #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_continuous (cfg_continuous),
    .cfg_settle     (cfg_settle),
    .cfg_window     (cfg_window),
    .adc_enable     (adc_enable),
    .adc_q          (adc_q),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int q_mode = 0;   // 0: adc_q low, 1: adc_q high, 2: toggle every cycle
  int en_cnt = 0;

  typedef struct {
    int data;
    int at;         // expected cycle of sample_valid, -1 = any
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit cont;
    int settle;
    int window;
    int qmode;
    int nwin;
    int expd;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_exp(input int data, input int at);
    exp_t e;
    e.data = data;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Quantizer stimulus generator
  initial forever begin
    @(posedge clk);
    #1;
    if (q_mode == 2) adc_q = ~adc_q;
    else             adc_q = q_mode[0];
  end

  // Output monitor: pops the scoreboard on every accepted sample
  exp_t got;
  initial forever begin
    @(negedge clk);
    if (adc_enable) en_cnt++;
    if (!rst && sample_valid && sample_ready) begin
      $display("sample data=%0d cycle=%0d", sample_data, cyc);
      if (sb.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        got = sb.pop_front();
        check("sample_data", int'(sample_data), got.data);
        if (got.at >= 0) check("sample_cycle", cyc, got.at);
      end
    end
  end

  // Wait for the scoreboard to drain, stop if continuous, then require idle.
  task automatic finish_run(input bit cont);
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 2000) begin tick(); budget++; end
    check("drain", sb.size(), 0);
    sb.delete();
    if (cont) begin
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
    end
    budget = 0;
    while (busy && budget < 2000) begin tick(); budget++; end
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_enable", int'(adc_enable), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int c, s, n;
    q_mode         = v.qmode;
    cfg_continuous = v.cont;
    cfg_settle     = CNT_W'(v.settle);
    cfg_window     = CNT_W'(v.window);
    repeat (4) tick();
    s = (v.settle < 2) ? 2 : v.settle;
    n = (v.window < 1) ? 1 : v.window;
    en_cnt    = 0;
    c         = cyc;
    cfg_start = 1'b1;
    for (int k = 0; k < v.nwin; k++) push_exp(v.expd, c + 1 + s + n + k * n);
    tick();
    cfg_start = 1'b0;
    finish_run(v.cont);
    if (!v.cont) check("enable_cycles", en_cnt, s + n);
    $display("vector settle=%0d window=%0d cont=%0d done", v.settle, v.window, v.cont);
  endtask

  initial begin
    int c;
    //            cont settle window qmode nwin expd
    vecs[0] = '{1'b0, 4,  8,  1, 1, 8};
    vecs[1] = '{1'b1, 2,  16, 2, 3, 8};
    vecs[2] = '{1'b0, 0,  0,  1, 1, 1};
    vecs[3] = '{1'b0, 0,  0,  0, 1, 0};
    vecs[4] = '{1'b0, 3,  5,  0, 1, 0};
    vecs[5] = '{1'b1, 2,  4,  1, 2, 4};
    vecs[6] = '{1'b0, 7,  3,  1, 1, 3};

    repeat (3) tick();
    @(negedge clk);
    check("reset_flags", int'({adc_enable, sample_valid, busy, overrun}), 0);
    check("reset_data", int'(sample_data), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start and stop in the same cycle: stop wins
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    @(negedge clk);
    check("start_stop_busy", int'(busy), 0);
    check("start_stop_enable", int'(adc_enable), 0);
    $display("start+stop same cycle done");

    // cfg_start while busy is ignored, including its new settings
    q_mode = 1; cfg_continuous = 1'b0; cfg_settle = 16'd4; cfg_window = 16'd8;
    repeat (3) tick();
    c = cyc;
    cfg_start = 1'b1;
    push_exp(8, c + 13);
    tick();
    cfg_start = 1'b0;
    wait_cyc(c + 5);
    cfg_window = 16'd2; cfg_settle = 16'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    finish_run(1'b0);
    $display("start while busy done");

    // stop in the middle of a long window
    cfg_settle = 16'd2; cfg_window = 16'd100;
    tick();
    c = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_cyc(c + 52);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    @(negedge clk);
    check("stop_enable", int'(adc_enable), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_valid", int'(sample_valid), 0);
    tick();
    c = cyc;
    cfg_start = 1'b1;
    push_exp(100, c + 103);
    tick();
    cfg_start = 1'b0;
    finish_run(1'b0);
    $display("stop mid-window done");

    // backpressure and overrun
    sample_ready = 1'b0; cfg_continuous = 1'b1; cfg_settle = 16'd2; cfg_window = 16'd4;
    tick();
    c = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_cyc(c + 7);
    @(negedge clk);
    check("bp_valid", int'(sample_valid), 1);
    check("bp_data", int'(sample_data), 4);
    check("bp_overrun_early", int'(overrun), 0);
    wait_cyc(c + 11);
    @(negedge clk);
    check("bp_overrun", int'(overrun), 1);
    check("bp_data_kept", int'(sample_data), 4);
    tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    @(negedge clk);
    check("bp_stop_busy", int'(busy), 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    tick();
    cfg_continuous = 1'b0;
    c = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    @(negedge clk);
    check("restart_overrun_clear", int'(overrun), 0);
    check("restart_busy", int'(busy), 1);
    wait_cyc(c + 7);
    @(negedge clk);
    check("bp_single_overrun", int'(overrun), 1);
    check("bp_single_busy", int'(busy), 0);
    check("bp_single_data", int'(sample_data), 4);
    tick();
    push_exp(4, -1);
    sample_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("bp_released_valid", int'(sample_valid), 0);
    check("bp_released_drain", sb.size(), 0);
    $display("backpressure done");

    // asynchronous reset mid-acquire with a sample held
    sample_ready = 1'b0; cfg_continuous = 1'b1;
    tick();
    c = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_cyc(c + 9);
    @(negedge clk);
    check("pre_reset_valid", int'(sample_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_flags", int'({adc_enable, sample_valid, busy, overrun}), 0);
    check("async_reset_data", int'(sample_data), 0);
    tick();
    rst = 1'b0;
    sample_ready = 1'b1;
    tick();
    @(negedge clk);
    check("post_reset_idle", int'({adc_enable, sample_valid, busy}), 0);
    $display("async reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
